// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix MAC engine.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package matrix_pkg;

    typedef enum logic [2:0] {
        OP_MULTIPLY  = 3'd0,
        OP_ADD       = 3'd1,
        OP_SUBTRACT  = 3'd2,
        OP_TRANSPOSE = 3'd3,
        OP_SCALE     = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Bit offset of element (r,c) inside a row-major packed N x N matrix.
    function automatic int elem_offset(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

    // Opcodes 5..7 are reserved and complete immediately with an error.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_SCALE);
    endfunction

endpackage

// File: rtl/matrix_mac.sv
// Multiply-accumulate unit: W x W product added to a running accumulator.
// Latency: o_sum is the combinational new sum; the accumulator register updates on the edge.
// Backpressure: none; i_en gates accumulator update, i_clr restarts the sum from zero.
module matrix_mac
    import matrix_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    // Wide enough to hold N full-width products without overflow.
    localparam int AW = 2 * W + $clog2(N);

    logic [2*W-1:0] w_prod;
    logic [AW-1:0]  w_base;
    logic [AW-1:0]  w_sum;
    logic [AW-1:0]  r_acc;

    assign w_prod = i_a * i_b;
    assign w_base = i_clr ? '0 : r_acc;
    assign w_sum  = w_base + AW'(w_prod);
    assign o_sum  = w_sum[W-1:0];

    // Accumulator register: holds the running sum of the current element.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/matrix_mac_engine.sv
// Sequential N x N matrix engine: multiply, add, subtract, transpose, scale.
// Latency: done N*N+1 cycles after accept (N*N*N+1 for multiply, 1 for illegal op).
// Backpressure: ready high only when idle; start while busy is dropped, not queued.
module matrix_mac_engine
    import matrix_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [N*N*W-1:0] srcA,
    input  logic [N*N*W-1:0] srcB,
    input  logic [W-1:0]     scalar,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [N*N*W-1:0] result
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] IMAX = CW'(N - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [2:0]      r_op;
    logic [W-1:0]    r_scalar;
    logic [W-1:0]    r_a   [N][N];
    logic [W-1:0]    r_b   [N][N];
    logic [W-1:0]    r_res [N][N];
    logic [W-1:0]    w_src_a [N][N];
    logic [W-1:0]    w_src_b [N][N];
    logic            r_err;
    logic [CW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   r_k;

    logic            w_accept;
    logic            w_legal;
    logic            w_is_mul;
    logic            w_k_last;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_elem_step;
    logic            w_last;
    logic            w_mac_en;
    logic            w_mac_clr;
    logic [W-1:0]    w_mac_a;
    logic [W-1:0]    w_mac_b;
    logic [W-1:0]    w_mac_sum;
    logic [W-1:0]    w_elem;

    // Unpack operand buses and pack the result register onto the output bus.
    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            assign w_src_a[gr][gc] = srcA[elem_offset(gr, gc, N, W) +: W];
            assign w_src_b[gr][gc] = srcB[elem_offset(gr, gc, N, W) +: W];
            assign result[elem_offset(gr, gc, N, W) +: W] = r_res[gr][gc];
        end
    end

    assign w_accept    = start && (r_state == ST_IDLE);
    assign w_legal     = op_is_legal(op);
    assign w_is_mul    = (r_op == OP_MULTIPLY);
    assign w_k_last    = (r_k == IMAX);
    assign w_col_last  = (r_col == IMAX);
    assign w_row_last  = (r_row == IMAX);
    // An element completes every cycle, except in multiply where it takes N products.
    assign w_elem_step = !w_is_mul || w_k_last;
    assign w_last      = w_elem_step && w_col_last && w_row_last;

    assign ready = (r_state == ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign err   = r_err;

    // State register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: illegal ops skip straight to DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_legal ? ST_COMPUTE : ST_DONE;
                end
            end
            ST_COMPUTE: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture operands on accept so later input changes cannot disturb the run.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_op     <= '0;
            r_scalar <= '0;
            r_a      <= '{default: '0};
            r_b      <= '{default: '0};
        end else if (w_accept) begin
            r_op     <= op;
            r_scalar <= scalar;
            r_a      <= w_src_a;
            r_b      <= w_src_b;
        end
    end

    // Error flag: set by an illegal accept, cleared by the next legal accept.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= !w_legal;
        end
    end

    // Row/column/k walk: k innermost (multiply only), then column, then row.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
        end else if (w_accept) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
        end else if (r_state == ST_COMPUTE) begin
            if (w_is_mul) begin
                r_k <= w_k_last ? '0 : r_k + CW'(1);
            end
            if (w_elem_step) begin
                r_col <= w_col_last ? '0 : r_col + CW'(1);
                if (w_col_last) begin
                    r_row <= w_row_last ? '0 : r_row + CW'(1);
                end
            end
        end
    end

    // The single MAC serves multiply (A(r,k)*B(k,c) summed over k) and scale (A(r,c)*scalar).
    always_comb begin
        w_mac_en  = (r_state == ST_COMPUTE);
        w_mac_clr = 1'b1;
        w_mac_a   = r_a[r_row][r_col];
        w_mac_b   = r_scalar;
        if (w_is_mul) begin
            w_mac_clr = (r_k == '0);
            w_mac_a   = r_a[r_row][r_k];
            w_mac_b   = r_b[r_k][r_col];
        end
    end

    matrix_mac #(
        .N (N),
        .W (W)
    ) u_mac (
        .Clk    (Clk),
        .nReset (nReset),
        .i_en   (w_mac_en),
        .i_clr  (w_mac_clr),
        .i_a    (w_mac_a),
        .i_b    (w_mac_b),
        .o_sum  (w_mac_sum)
    );

    // Element value for the current (row,col); arithmetic wraps at W bits.
    always_comb begin
        w_elem = w_mac_sum;
        case (r_op)
            OP_ADD:       w_elem = r_a[r_row][r_col] + r_b[r_row][r_col];
            OP_SUBTRACT:  w_elem = r_a[r_row][r_col] - r_b[r_row][r_col];
            OP_TRANSPOSE: w_elem = r_a[r_col][r_row];
            default:      w_elem = w_mac_sum;
        endcase
    end

    // Result register: one element written per completed element step.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_res <= '{default: '0};
        end else if ((r_state == ST_COMPUTE) && w_elem_step) begin
            r_res[r_row][r_col] <= w_elem;
        end
    end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Self-checking bench for matrix_mac_engine with a behavioural matrix model.
// Latency: checks done timing against N*N+1 / N*N*N+1 / 1 cycles.
// Backpressure: exercises start while busy and start during done.
module tb_matrix_mac_engine;

    localparam int N = 4;
    localparam int W = 16;
    typedef logic [N*N*W-1:0] mat_t;

    logic         Clk    = 1'b0;
    logic         nReset = 1'b0;
    logic         start  = 1'b0;
    logic [2:0]   op     = '0;
    mat_t         srcA   = '0;
    mat_t         srcB   = '0;
    logic [W-1:0] scalar = '0;
    logic         ready;
    logic         done;
    logic         err;
    mat_t         result;

    int   total   = 0;
    int   bad     = 0;
    mat_t exp_res = '0;

    always #5 Clk = ~Clk;

    matrix_mac_engine #(
        .N (N),
        .W (W)
    ) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .scalar (scalar),
        .ready  (ready),
        .done   (done),
        .err    (err),
        .result (result)
    );

    function automatic logic [W-1:0] get(input mat_t m, input int r, input int c);
        mat_t t;
        t = m >> ((r * N + c) * W);
        return t[W-1:0];
    endfunction

    // Sets element (r,c) of a matrix whose slot is still zero.
    function automatic mat_t put(input mat_t m, input int r, input int c, input logic [W-1:0] v);
        mat_t t;
        t = '0;
        t[W-1:0] = v;
        return m | (t << ((r * N + c) * W));
    endfunction

    function automatic mat_t rnd_mat();
        mat_t m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m = put(m, r, c, W'($urandom));
        return m;
    endfunction

    // Reference: plain matrix arithmetic, low W bits kept; illegal op leaves prev.
    function automatic mat_t model(input logic [2:0] o, input mat_t a, input mat_t b,
                                   input logic [W-1:0] s, input mat_t prev);
        mat_t m = '0;
        if (o > 3'd4) return prev;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                longint v;
                v = 0;
                case (o)
                    3'd0: for (int k = 0; k < N; k++)
                              v += longint'(get(a, r, k)) * longint'(get(b, k, c));
                    3'd1: v = longint'(get(a, r, c)) + longint'(get(b, r, c));
                    3'd2: v = longint'(get(a, r, c)) - longint'(get(b, r, c));
                    3'd3: v = longint'(get(a, c, r));
                    default: v = longint'(get(a, r, c)) * longint'(s);
                endcase
                m = put(m, r, c, v[W-1:0]);
            end
        end
        return m;
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        if (o > 3'd4) return 1;
        if (o == 3'd0) return N * N * N + 1;
        return N * N + 1;
    endfunction

    // Drives one operation and waits (bounded) for done; returns at the done-cycle negedge.
    task automatic run_op(input logic [2:0] o, input mat_t a, input mat_t b, input logic [W-1:0] s,
                          input bit scramble, input bit poke,
                          output int lat, output logic e, output mat_t res, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        @(negedge Clk);
        op = o; srcA = a; srcB = b; scalar = s; start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        if (scramble) begin
            srcA = rnd_mat(); srcB = rnd_mat(); scalar = W'($urandom); op = 3'($urandom_range(0, 7));
        end
        for (int i = 1; i <= 200; i++) begin
            @(negedge Clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (ready !== 1'b0) busy_ok = 1'b0;
            if (poke) begin
                start = (i % 4 == 2);
                op    = 3'($urandom_range(0, 7));
                srcA  = rnd_mat();
                srcB  = rnd_mat();
            end
        end
        start = 1'b0;
        e     = err;
        res   = result;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        @(posedge Clk);
        #1 nReset = 1'b1;
    endtask

    task automatic test_add_first();
        mat_t a = '0, b = '0, res;
        int lat; logic e; bit bz;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a = put(a, r, c, W'(r * 4 + c + 1));
                b = put(b, r, c, W'(2));
            end
        run_op(3'd1, a, b, '0, 1'b0, 1'b0, lat, e, res, bz);
        exp_res = model(3'd1, a, b, '0, exp_res);
        total++; if (lat != 17) begin bad++; $display("FAIL add_latency got=%0d want=17", lat); end
        total++; if (get(res, 3, 2) !== 16'd17) begin bad++; $display("FAIL add_elem32 got=%0d want=17", get(res, 3, 2)); end
        total++; if (res !== exp_res) begin bad++; $display("FAIL add_result got=%h want=%h", res, exp_res); end
        total++; if (bz !== 1'b1) begin bad++; $display("FAIL add_ready_busy got=%b want=1", bz); end
    endtask

    task automatic test_multiply();
        mat_t a = '0, id = '0, res;
        int lat; logic e; bit bz;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a  = put(a, r, c, W'(r * 4 + c + 1));
                id = put(id, r, c, (r == c) ? W'(1) : W'(0));
            end
        run_op(3'd0, a, id, '0, 1'b0, 1'b0, lat, e, res, bz);
        exp_res = model(3'd0, a, id, '0, exp_res);
        total++; if (lat != 65) begin bad++; $display("FAIL mul_id_latency got=%0d want=65", lat); end
        total++; if (res !== a) begin bad++; $display("FAIL mul_identity got=%h want=%h", res, a); end
        run_op(3'd0, a, a, '0, 1'b0, 1'b0, lat, e, res, bz);
        exp_res = model(3'd0, a, a, '0, exp_res);
        total++; if (get(res, 0, 0) !== 16'd90) begin bad++; $display("FAIL mul_sq_00 got=%0d want=90", get(res, 0, 0)); end
        total++; if (get(res, 3, 3) !== 16'd600) begin bad++; $display("FAIL mul_sq_33 got=%0d want=600", get(res, 3, 3)); end
        total++; if (res !== exp_res) begin bad++; $display("FAIL mul_sq got=%h want=%h", res, exp_res); end
    endtask

    task automatic test_sub_scale();
        mat_t ones = '0, big = '0, res;
        int lat; logic e; bit bz;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ones = put(ones, r, c, W'(1));
                big  = put(big, r, c, 16'h8000);
            end
        run_op(3'd2, '0, ones, '0, 1'b0, 1'b0, lat, e, res, bz);
        exp_res = model(3'd2, '0, ones, '0, exp_res);
        total++; if (res !== {(N*N*W){1'b1}}) begin bad++; $display("FAIL sub_wrap got=%h want=all ones", res); end
        run_op(3'd4, big, ones, W'(2), 1'b0, 1'b0, lat, e, res, bz);
        exp_res = model(3'd4, big, ones, W'(2), exp_res);
        total++; if (res !== '0) begin bad++; $display("FAIL scale_wrap got=%h want=0", res); end
        total++; if (lat != 17) begin bad++; $display("FAIL scale_latency got=%0d want=17", lat); end
    endtask

    task automatic test_transpose();
        mat_t a = '0, t = '0, res;
        int lat; logic e; bit bz;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a = put(a, r, c, W'(r * 4 + c));
                t = put(t, r, c, W'(c * 4 + r));
            end
        run_op(3'd3, a, rnd_mat(), '0, 1'b1, 1'b0, lat, e, res, bz);
        exp_res = t;
        total++; if (res !== t) begin bad++; $display("FAIL transpose got=%h want=%h", res, t); end
    endtask

    task automatic test_illegal();
        mat_t a, b, res;
        int lat; logic e; bit bz;
        run_op(3'd6, rnd_mat(), rnd_mat(), '0, 1'b0, 1'b0, lat, e, res, bz);
        total++; if (lat != 1) begin bad++; $display("FAIL illegal_latency got=%0d want=1", lat); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b want=1", e); end
        total++; if (res !== exp_res) begin bad++; $display("FAIL illegal_result got=%h want=%h", res, exp_res); end
        a = rnd_mat(); b = rnd_mat();
        run_op(3'd1, a, b, '0, 1'b0, 1'b0, lat, e, res, bz);
        exp_res = model(3'd1, a, b, '0, exp_res);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", e); end
        total++; if (res !== exp_res) begin bad++; $display("FAIL add_after_illegal got=%h want=%h", res, exp_res); end
    endtask

    task automatic test_back_to_back();
        mat_t a = rnd_mat(), b = rnd_mat(), res;
        int lat; logic e; bit bz;
        run_op(3'd0, a, b, '0, 1'b0, 1'b1, lat, e, res, bz);
        exp_res = model(3'd0, a, b, '0, exp_res);
        total++; if (lat != 65) begin bad++; $display("FAIL poke_latency got=%0d want=65", lat); end
        total++; if (res !== exp_res) begin bad++; $display("FAIL poke_result got=%h want=%h", res, exp_res); end
        total++; if (bz !== 1'b1) begin bad++; $display("FAIL poke_ready_busy got=%b want=1", bz); end
        // Still in the done cycle: a start here must be dropped.
        start = 1'b1; op = 3'd7;
        @(negedge Clk);
        start = 1'b0;
        total++; if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL start_at_done got=r%b d%b e%b want=r1 d0 e0", ready, done, err);
        end
    endtask

    task automatic test_reset_mid();
        mat_t a = rnd_mat(), b = rnd_mat(), res;
        int lat; int dones; logic e; bit bz;
        @(negedge Clk);
        op = 3'd1; srcA = a; srcB = b; start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (10) @(negedge Clk);
        nReset = 1'b0;
        #1;
        exp_res = '0;
        total++; if (result !== '0) begin bad++; $display("FAIL rst_mid_result got=%h want=0", result); end
        total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got=r%b d%b want=r1 d0", ready, done); end
        @(posedge Clk);
        #1 nReset = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d want=0", dones); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", ready); end
        run_op(3'd1, a, b, '0, 1'b0, 1'b0, lat, e, res, bz);
        exp_res = model(3'd1, a, b, '0, exp_res);
        total++; if (lat != 17) begin bad++; $display("FAIL rst_mid_next_latency got=%0d want=17", lat); end
        total++; if (res !== exp_res) begin bad++; $display("FAIL rst_mid_next_result got=%h want=%h", res, exp_res); end
    endtask

    task automatic test_random();
        mat_t a, b, res;
        logic [W-1:0] s;
        logic [2:0] o;
        int lat; logic e; bit bz;
        for (int it = 0; it < 24; it++) begin
            a = rnd_mat(); b = rnd_mat(); s = W'($urandom);
            o = 3'($urandom_range(0, 7));
            run_op(o, a, b, s, 1'($urandom), 1'($urandom), lat, e, res, bz);
            exp_res = model(o, a, b, s, exp_res);
            total++; if (lat != lat_of(o)) begin bad++; $display("FAIL rnd_latency it=%0d op=%0d got=%0d want=%0d", it, o, lat, lat_of(o)); end
            total++; if (e !== (o > 3'd4)) begin bad++; $display("FAIL rnd_err it=%0d op=%0d got=%b want=%b", it, o, e, (o > 3'd4)); end
            total++; if (res !== exp_res) begin bad++; $display("FAIL rnd_result it=%0d op=%0d got=%h want=%h", it, o, res, exp_res); end
        end
    endtask

    initial begin
        test_reset();
        test_add_first();
        test_multiply();
        test_sub_scale();
        test_transpose();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
